// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//   Shares one unsigned array multiplier between two requesters.
//   - When idle, one requester is granted. If both are requesting, the grant
//     goes to the one that was not granted last (round-robin).
//   - The granted operands are captured into op_a/op_b.
//   - The product is registered one cycle later.
//   - The product is then held until the consumer accepts it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/req0_a/req0_b    requester 0 operand pair
//   req0_ready                  requester 0 accepted (IDLE only)
//   req1_valid/req1_a/req1_b    requester 1 operand pair
//   req1_ready                  requester 1 accepted (IDLE only)
//   resp_valid/resp_ready       response handshake
//   product                     2*DW unsigned product
//   resp_id                     requester that owns product
//   busy                        high whenever not IDLE
//
// Only DW=8 is supported.
// -----------------------------------------------------------------------------
module array_multiplier #(
  parameter int DW = 8
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] p
);
  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] acc;

  assign a_ext = {{DW{1'b0}}, a};

  // Shift-and-add over the rows of the partial-product array.
  always_comb begin
    acc = '0;
    for (int i = 0; i < DW; i++) begin
      if (b[i]) acc = acc + (a_ext << i);
    end
  end

  assign p = acc;
endmodule

module mult_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            req1_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [2*DW-1:0] product,
  output logic            resp_id,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   op_a, op_b;
  logic            id_q;
  logic            last_grant;
  logic            grant0, grant1;
  logic [2*DW-1:0] mult_p;

  array_multiplier #(.DW(DW)) u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

  // Next state and the combinational ready lines (IDLE grant only).
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // A tie goes to whichever requester did not win last time.
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) state_next = CALC;
      end
      CALC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequential state.
  // - The handshake captures operands, the requester id and the new last_grant.
  // - CALC registers the product.
  // - The reset value of last_grant makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      product    <= '0;
      resp_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && (grant0 | grant1)) begin
        op_a       <= grant1 ? req1_a : req0_a;
        op_b       <= grant1 ? req1_b : req0_b;
        id_q       <= grant1;
        last_grant <= grant1;
      end
      if (state == CALC) begin
        product    <= mult_p;
        resp_valid <= 1'b1;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign resp_id = id_q;
  assign busy    = (state != IDLE);
endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_ready;
  logic [15:0] product;
  logic        resp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mult_arbiter #(.DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .product    (product),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits up to 10 falling edges for resp_valid.
  task automatic wait_resp(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    resp_ready = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({resp_valid, product, resp_id, busy, req0_ready, req1_ready} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: rv=%0b p=%0d id=%0b busy=%0b r0=%0b r1=%0b, required all 0",
               resp_valid, product, resp_id, busy, req0_ready, req1_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_req0_alone();
    bit seen;
    @(negedge clk);
    req0_valid = 1; req0_a = 8'd4; req0_b = 8'd2; resp_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL req0_grant: r0=%0b r1=%0b, required 1/0", req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL req0_calc: busy=%0b rv=%0b r0=%0b, required 1/0/0", busy, resp_valid, req0_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || product !== 16'd8 || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL req0_resp: rv=%0b p=%0d id=%0b, required 1/8/0", resp_valid, product, resp_id);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL req0_done: rv=%0b busy=%0b, required 0/0", resp_valid, busy);
    end
    seen = 1'b0;
  endtask

  task automatic test_req1_alone();
    bit seen;
    bit r0_seen;
    r0_seen = 1'b0;
    @(negedge clk);
    req1_valid = 1; req1_a = 8'd12; req1_b = 8'd3; resp_ready = 1;
    #1;
    r0_seen |= req0_ready;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    r0_seen |= req0_ready;
    wait_resp(seen);
    r0_seen |= req0_ready;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL req1_timeout: resp_valid=0 after 10 cycles, required 1");
    end else if (product !== 16'd36 || resp_id !== 1'b1) begin
      errors++;
      $display("FAIL req1_resp: p=%0d id=%0b, required 36/1", product, resp_id);
    end
    @(negedge clk);
    r0_seen |= req0_ready;
    checks++;
    if (r0_seen !== 1'b0) begin
      errors++;
      $display("FAIL req1_r0_ready: req0_ready seen=%0b, required 0", r0_seen);
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    logic        exp_id  [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] exp_p   [3] = '{16'd65025, 16'd0, 16'd65025};
    test_reset();
    @(negedge clk);
    req0_valid = 1; req0_a = 8'd255; req0_b = 8'd255;
    req1_valid = 1; req1_a = 8'd0;   req1_b = 8'd7;
    resp_ready = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rr_first_grant: r0=%0b r1=%0b, required 1/0", req0_ready, req1_ready);
    end
    for (int k = 0; k < 3; k++) begin
      wait_resp(seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rr_timeout: response %0d missing", k);
      end else if (resp_id !== exp_id[k] || product !== exp_p[k]) begin
        errors++;
        $display("FAIL rr_resp%0d: id=%0b p=%0d, required %0b/%0d", k, resp_id, product, exp_id[k], exp_p[k]);
      end
    end
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit seen;
    @(negedge clk);
    req0_valid = 1; req0_a = 8'd5; req0_b = 8'd6; resp_ready = 0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant: r0=%0b, required 1", req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_a = 8'd1; req1_b = 8'd1;
    wait_resp(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_timeout: resp_valid never rose");
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || product !== 16'd30 || resp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%0b p=%0d id=%0b r0=%0b r1=%0b busy=%0b, required 1/30/0/0/0/1",
                 c, resp_valid, product, resp_id, req0_ready, req1_ready, busy);
      end
      @(negedge clk);
    end
    resp_ready = 1;
    req1_valid = 0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rv=%0b busy=%0b, required 0/0", resp_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_dropped_req: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit bad;
    test_reset();
    @(negedge clk);
    req1_valid = 1; req1_a = 8'd9; req1_b = 8'd9; resp_ready = 1;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_grant: r0=%0b r1=%0b, required 0/1", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req1_valid = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_calc: busy=%0b, required 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || product !== 16'd0 || busy !== 1'b0 || resp_id !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: rv=%0b p=%0d busy=%0b id=%0b, required 0/0/0/0", resp_valid, product, busy, resp_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid || product == 16'd81) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resp: stale response seen=%0b, required 0", bad);
    end
    req0_valid = 1; req0_a = 8'd1; req0_b = 8'd1;
    req1_valid = 1; req1_a = 8'd1; req1_b = 8'd1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_tie: r0=%0b r1=%0b, required 1/0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_req0_alone();
    test_req1_alone();
    test_round_robin();
    test_backpressure();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
